// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : MEM-stage data memory access controller. Turns a load/store
//               in the EX/MEM slot into a single request on the data-RAM
//               channel, stalls the pipeline while the request is
//               outstanding, registers the load result for MEM/WB and aborts
//               with a bus_err pulse if the RAM does not acknowledge within
//               TIMEOUT_CYCLES ACCESS-state cycles.
//
// Parameters  : TIMEOUT_CYCLES - ACCESS cycles to wait for bus_ack (2..255)
//
// Ports       : clk, reset (async, active-low)
//               mem_valid, MemRead, MemWrite, ALUResult, WriteData - MEM slot
//               bus_req, bus_we, bus_addr, bus_wdata                - RAM req
//               bus_ack, bus_rdata                                  - RAM resp
//               ReadData  - registered load result
//               stall     - hold IF..EX/MEM, deassert MEM/WB enable
//               bus_err   - one-cycle pulse on timeout abort
//               misalign_err - one-cycle pulse on misaligned access
//
// Config      : MEM_ALIGN_CHECK_EN - when defined, accesses with
//               ALUResult[1:0] != 0 are rejected without a bus request.
//               When undefined, misalign_err is tied low and every address
//               is passed to the bus unchanged.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        bus_err,
    output logic        misalign_err
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    // Counter value seen on the final permitted ACCESS cycle.
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_read_data;
    logic        r_bus_err;
    logic        r_misalign_err;

    logic        w_access;
    logic        w_misalign;

    assign w_access = mem_valid & (MemRead | MemWrite);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (ALUResult[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= c_IDLE;
            r_cnt          <= 8'd0;
            r_bus_we       <= 1'b0;
            r_bus_addr     <= 32'd0;
            r_bus_wdata    <= 32'd0;
            r_read_data    <= 32'd0;
            r_bus_err      <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            // Error flags are single-cycle pulses that live only in DONE.
            r_bus_err      <= 1'b0;
            r_misalign_err <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (w_access) begin
                        if (w_misalign) begin
                            // Rejected access: skip the bus entirely.
                            r_misalign_err <= 1'b1;
                            r_state        <= c_DONE;
                        end else begin
                            r_bus_addr  <= ALUResult;
                            r_bus_wdata <= WriteData;
                            // A store wins when both read and write are set.
                            r_bus_we    <= MemWrite;
                            r_cnt       <= 8'd0;
                            r_state     <= c_ACCESS;
                        end
                    end
                end

                c_ACCESS: begin
                    // Ack is checked first so that an ack arriving on the
                    // timeout cycle completes normally.
                    if (bus_ack) begin
                        if (!r_bus_we) begin
                            r_read_data <= bus_rdata;
                        end
                        r_state <= c_DONE;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_read_data <= 32'h0000_0000;
                        r_bus_err   <= 1'b1;
                        r_state     <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                c_DONE: begin
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // bus_req is decoded from state so an asynchronous reset drops it at once.
    assign bus_req = (r_state == c_ACCESS);

    // The IDLE term is combinational so the pipeline is frozen in the same
    // cycle the access is detected; it is masked while reset is asserted.
    assign stall = reset & (((r_state == c_IDLE) & w_access) | (r_state == c_ACCESS));

    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign ReadData     = r_read_data;
    assign bus_err      = r_bus_err;
    assign misalign_err = r_misalign_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access (TIMEOUT_CYCLES = 4).
//               Directed vector table, hand-written corner sequences and
//               randomized transactions checked against a transaction-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, MemRead, MemWrite;
    logic [31:0] ALUResult, WriteData;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [31:0] ReadData;
    logic        stall, bus_err, misalign_err;

    int total = 0;
    int bad   = 0;

    mem_access #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_valid    (mem_valid),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .ALUResult    (ALUResult),
        .WriteData    (WriteData),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .ReadData     (ReadData),
        .stall        (stall),
        .bus_err      (bus_err),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One transaction: IDLE detect cycle, ACCESS cycles, DONE cycle.
    // bus_ack is raised on ACCESS cycle index ack_delay (0-based).
    task automatic run_txn(input logic w, input logic r, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int ack_delay, input logic keep_valid,
                           output int acc, output int stl, output logic err,
                           output logic mis, output logic [31:0] rd, output logic stable);
        int guard;
        acc = 0; stl = 0; err = 1'b0; mis = 1'b0; rd = 32'd0; stable = 1'b1;
        @(negedge clk);
        mem_valid = 1'b1; MemRead = r; MemWrite = w;
        ALUResult = addr; WriteData = wdata; bus_ack = 1'b0;
        #1;
        chk("idle_no_req", {31'd0, bus_req}, 32'd0);
        chk("idle_err_clear", {30'd0, bus_err, misalign_err}, 32'd0);
        if (stall) stl++;
        guard = 0;
        forever begin
            @(negedge clk);
            #1;
            guard++;
            if (guard > 40) begin
                total++; bad++;
                $display("FAIL cycle_budget: got no DONE want DONE within 40 cycles");
                break;
            end
            if (bus_req) begin
                if (bus_addr !== addr || bus_wdata !== wdata || bus_we !== w) stable = 1'b0;
                bus_ack   = (acc == ack_delay);
                bus_rdata = rdata;
                #1;
                if (stall) stl++;
                acc++;
            end else begin
                if (!keep_valid) mem_valid = 1'b0;
                bus_ack   = 1'b0;
                bus_rdata = 32'hBAD0_BAD0;
                #1;
                if (stall) stl++;
                err = bus_err; mis = misalign_err; rd = ReadData;
                break;
            end
        end
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        int          exp_acc;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[7];

    task automatic check_txn(input string tag, input int acc, input int stl, input logic err,
                             input logic mis, input logic [31:0] rd, input logic stable,
                             input int exp_acc, input logic exp_err, input logic [31:0] exp_rd);
        chk({tag, "_access_cycles"}, acc, exp_acc);
        chk({tag, "_stall_cycles"}, stl, exp_acc + 1);
        chk({tag, "_bus_err"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, "_misalign"}, {31'd0, mis}, 32'd0);
        chk({tag, "_readdata"}, rd, exp_rd);
        chk({tag, "_req_stable"}, {31'd0, stable}, 32'd1);
    endtask

    initial begin
        int acc, stl, d;
        logic err, mis, stable, w, r;
        logic [31:0] rd, exp_rd, addr, wdata, rdata;

        tbl[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0,         32'hCAFE_F00D, 0, 1, 1'b0, 32'hCAFE_F00D};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h1234_5678, 32'h5555_5555, 3, 4, 1'b0, 32'hCAFE_F00D};
        tbl[2] = '{1'b0, 1'b1, 32'h0000_0300, 32'h0,         32'h9999_9999, 9, 4, 1'b1, 32'h0000_0000};
        tbl[3] = '{1'b0, 1'b1, 32'h0000_0304, 32'h0,         32'hA5A5_0001, 2, 3, 1'b0, 32'hA5A5_0001};
        tbl[4] = '{1'b1, 1'b1, 32'h0000_0308, 32'h0BAD_BEEF, 32'h1111_2222, 1, 2, 1'b0, 32'hA5A5_0001};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_030C, 32'h0F0F_0F0F, 32'h3333_4444, 9, 4, 1'b1, 32'h0000_0000};
        tbl[6] = '{1'b0, 1'b1, 32'h0000_0310, 32'h0,         32'h7777_8888, 3, 4, 1'b0, 32'h7777_8888};

        // Reset state
        reset = 1'b0; mem_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
        ALUResult = 32'h10; WriteData = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_readdata", ReadData, 32'd0);
        chk("rst_errs", {30'd0, bus_err, misalign_err}, 32'd0);
        mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].w, tbl[i].r, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
                    tbl[i].dly, 1'b0, acc, stl, err, mis, rd, stable);
            check_txn($sformatf("vec%0d", i), acc, stl, err, mis, rd, stable,
                      tbl[i].exp_acc, tbl[i].exp_err, tbl[i].exp_rd);
        end
        exp_rd = 32'h7777_8888;

        // No access: mem_valid low, and valid without read/write; stray ack ignored
        @(negedge clk);
        mem_valid = 1'b0; MemRead = 1'b1; MemWrite = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'hEEEE_EEEE;
        #1;
        chk("noacc_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        mem_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        chk("noacc_rw0_stall", {31'd0, stall}, 32'd0);
        chk("noacc_req", {31'd0, bus_req}, 32'd0);
        chk("stray_ack_rd", ReadData, exp_rd);
        bus_ack = 1'b0; mem_valid = 1'b0;

        // Back-to-back loads with mem_valid held
        run_txn(1'b0, 1'b1, 32'h0000_0400, 32'h0, 32'h0101_0101, 0, 1'b1,
                acc, stl, err, mis, rd, stable);
        check_txn("b2b_a", acc, stl, err, mis, rd, stable, 1, 1'b0, 32'h0101_0101);
        run_txn(1'b0, 1'b1, 32'h0000_0404, 32'h0, 32'h0202_0202, 0, 1'b0,
                acc, stl, err, mis, rd, stable);
        check_txn("b2b_b", acc, stl, err, mis, rd, stable, 1, 1'b0, 32'h0202_0202);
        exp_rd = 32'h0202_0202;

        // Load at 0x102
`ifdef MEM_ALIGN_CHECK_EN
        run_txn(1'b0, 1'b1, 32'h0000_0102, 32'h0, 32'h6666_6666, 0, 1'b0,
                acc, stl, err, mis, rd, stable);
        chk("mis_access_cycles", acc, 0);
        chk("mis_stall_cycles", stl, 1);
        chk("mis_pulse", {31'd0, mis}, 32'd1);
        chk("mis_readdata", rd, exp_rd);
`else
        run_txn(1'b0, 1'b1, 32'h0000_0102, 32'h0, 32'h6666_6666, 0, 1'b0,
                acc, stl, err, mis, rd, stable);
        check_txn("unaligned", acc, stl, err, mis, rd, stable, 1, 1'b0, 32'h6666_6666);
        exp_rd = 32'h6666_6666;
`endif

        // Reset in the 2nd ACCESS cycle, then a stray ack after release
        @(negedge clk);
        mem_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; ALUResult = 32'h0000_0500;
        bus_ack = 1'b0;
        @(negedge clk); #1;
        chk("rstmid_req_c1", {31'd0, bus_req}, 32'd1);
        @(negedge clk); #1;
        chk("rstmid_req_c2", {31'd0, bus_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rstmid_req_drop", {31'd0, bus_req}, 32'd0);
        chk("rstmid_stall", {31'd0, stall}, 32'd0);
        chk("rstmid_readdata", ReadData, 32'd0);
        mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_0001;
        #1;
        chk("rstmid_stray_req", {31'd0, bus_req}, 32'd0);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk("rstmid_stray_rd", ReadData, 32'd0);
        chk("rstmid_stray_stall", {31'd0, stall}, 32'd0);
        exp_rd = 32'd0;

        // Randomized transactions against the reference model
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            addr = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
            addr[1:0] = 2'b00;
`endif
            wdata = $urandom;
            rdata = $urandom;
            d = $urandom_range(0, T + 2);
            run_txn(w, r, addr, wdata, rdata, d, 1'($urandom_range(0, 1)),
                    acc, stl, err, mis, rd, stable);
            if (d >= T)  exp_rd = 32'd0;
            else if (!w) exp_rd = rdata;
            check_txn($sformatf("rnd%0d", n), acc, stl, err, mis, rd, stable,
                      (d < T) ? d + 1 : T, (d >= T), exp_rd);
        end

        @(negedge clk);
        mem_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
